// File: rtl/ram_bist_pkg.sv
// Shared types and the expected-data function for the RAM BIST controller.
// The data function works at a fixed 64-bit width; callers cast to their own widths.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR0  = 3'd1,
    S_RD0  = 3'd2,
    S_CHK0 = 3'd3,
    S_WR1  = 3'd4,
    S_RD1  = 3'd5,
    S_CHK1 = 3'd6,
    S_DONE = 3'd7
  } bist_state_t;

  localparam logic PH_NORMAL = 1'b0;
  localparam logic PH_INVERT = 1'b1;

  localparam int EXP_W = 64;

  // Phase 0 writes seed^addr; phase 1 writes its complement, so every bit toggles.
  function automatic logic [EXP_W-1:0] exp_data(
    input logic [EXP_W-1:0] addr,
    input logic             phase,
    input logic [EXP_W-1:0] pattern
  );
    logic [EXP_W-1:0] v_base;
    v_base = pattern ^ addr;
    return (phase == PH_INVERT) ? ~v_base : v_base;
  endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// Read-data checker: one-stage pipeline of issued read address/phase, comparator,
// sticky first-fail capture and mismatch counter.
module ram_bist_checker
  import ram_bist_pkg::*;
#(
  parameter int                 D_WIDTH = 16,
  parameter int                 A_WIDTH = 4,
  parameter logic [D_WIDTH-1:0] PATTERN = 16'hA5C3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_rd_en,
  input  logic [A_WIDTH-1:0] i_rd_addr,
  input  logic               i_rd_phase,
  input  logic [D_WIDTH-1:0] i_data_read,
  output logic               o_fail,
  output logic [A_WIDTH-1:0] o_fail_addr,
  output logic [A_WIDTH+1:0] o_err_count
);

  logic               r_pipe_valid;
  logic [A_WIDTH-1:0] r_pipe_addr;
  logic               r_pipe_phase;
  logic               r_fail;
  logic [A_WIDTH-1:0] r_fail_addr;
  logic [A_WIDTH+1:0] r_err_count;

  logic [D_WIDTH-1:0] w_exp;
  logic               w_mismatch;

  assign w_exp      = D_WIDTH'(exp_data(EXP_W'(r_pipe_addr), r_pipe_phase, EXP_W'(PATTERN)));
  assign w_mismatch = r_pipe_valid && (i_data_read != w_exp);

  // The RAM returns data one cycle after en_read, so the pipeline stage lines up
  // the issued address with the data arriving in the current cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pipe_valid <= 1'b0;
      r_pipe_addr  <= '0;
      r_pipe_phase <= PH_NORMAL;
      r_fail       <= 1'b0;
      r_fail_addr  <= '0;
      r_err_count  <= '0;
    end else begin
      r_pipe_valid <= i_rd_en;
      r_pipe_addr  <= i_rd_addr;
      r_pipe_phase <= i_rd_phase;
      if (i_clear) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_err_count <= '0;
      end else if (w_mismatch) begin
        r_err_count <= r_err_count + (A_WIDTH+2)'(1);
        if (!r_fail) begin
          r_fail      <= 1'b1;
          r_fail_addr <= r_pipe_addr;
        end
      end
    end
  end

  assign o_fail      = r_fail;
  assign o_fail_addr = r_fail_addr;
  assign o_err_count = r_err_count;

endmodule

// File: rtl/ram_bist_ctrl.sv
// BIST initiator for the simple dual-port RAM: write pattern, read/compare,
// write inverse, read/compare; reports pass/fail, first failing address, error count.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int                 D_WIDTH = 16,
  parameter int                 A_WIDTH = 4,
  parameter int                 A_MAX   = 16,
  parameter logic [D_WIDTH-1:0] PATTERN = 16'hA5C3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               en_write,
  output logic               write_enable,
  output logic [A_WIDTH-1:0] address_write,
  output logic [D_WIDTH-1:0] data_write,
  output logic               en_read,
  output logic [A_WIDTH-1:0] address_read,
  input  logic [D_WIDTH-1:0] data_read,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [A_WIDTH-1:0] fail_addr,
  output logic [A_WIDTH+1:0] err_count,
  output bist_state_t        dbg_state
);

  localparam logic [A_WIDTH-1:0] A_LAST = A_WIDTH'(A_MAX - 1);

  bist_state_t        r_state;
  logic [A_WIDTH-1:0] r_addr;
  logic               r_phase;
  logic               r_en_write;
  logic [A_WIDTH-1:0] r_address_write;
  logic [D_WIDTH-1:0] r_data_write;
  logic               r_en_read;
  logic [A_WIDTH-1:0] r_address_read;
  logic               r_busy;
  logic               r_done;

  logic [A_WIDTH-1:0] w_addr_inc;
  logic               w_start_accept;

  function automatic logic [D_WIDTH-1:0] f_exp(input logic [A_WIDTH-1:0] a, input logic ph);
    return D_WIDTH'(exp_data(EXP_W'(a), ph, EXP_W'(PATTERN)));
  endfunction

  assign w_addr_inc     = r_addr + A_WIDTH'(1);
  assign w_start_accept = (r_state == S_IDLE) && start;

  // start is a level sampled only in IDLE; done is a single-cycle pulse and
  // busy stays high from the accepting edge until the edge after done.
  // r_addr always mirrors the address currently presented on the RAM port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_phase         <= PH_NORMAL;
      r_en_write      <= 1'b0;
      r_address_write <= '0;
      r_data_write    <= '0;
      r_en_read       <= 1'b0;
      r_address_read  <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_en_write      <= 1'b0;
      r_address_write <= '0;
      r_data_write    <= '0;
      r_en_read       <= 1'b0;
      r_address_read  <= '0;
      r_done          <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state         <= S_WR0;
            r_phase         <= PH_NORMAL;
            r_addr          <= '0;
            r_busy          <= 1'b1;
            r_en_write      <= 1'b1;
            r_data_write    <= f_exp('0, PH_NORMAL);
          end
        end
        S_WR0, S_WR1: begin
          if (r_addr == A_LAST) begin
            r_state   <= (r_state == S_WR0) ? S_RD0 : S_RD1;
            r_addr    <= '0;
            r_en_read <= 1'b1;
          end else begin
            r_addr          <= w_addr_inc;
            r_en_write      <= 1'b1;
            r_address_write <= w_addr_inc;
            r_data_write    <= f_exp(w_addr_inc, r_phase);
          end
        end
        S_RD0, S_RD1: begin
          if (r_addr == A_LAST) begin
            r_state <= (r_state == S_RD0) ? S_CHK0 : S_CHK1;
            r_addr  <= '0;
          end else begin
            r_addr         <= w_addr_inc;
            r_en_read      <= 1'b1;
            r_address_read <= w_addr_inc;
          end
        end
        S_CHK0: begin
          r_state      <= S_WR1;
          r_phase      <= PH_INVERT;
          r_addr       <= '0;
          r_en_write   <= 1'b1;
          r_data_write <= f_exp('0, PH_INVERT);
        end
        S_CHK1: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  ram_bist_checker #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH),
    .PATTERN (PATTERN)
  ) u_checker (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_start_accept),
    .i_rd_en     (r_en_read),
    .i_rd_addr   (r_address_read),
    .i_rd_phase  (r_phase),
    .i_data_read (data_read),
    .o_fail      (fail),
    .o_fail_addr (fail_addr),
    .o_err_count (err_count)
  );

  assign en_write      = r_en_write;
  assign write_enable  = r_en_write;
  assign address_write = r_address_write;
  assign data_write    = r_data_write;
  assign en_read       = r_en_read;
  assign address_read  = r_address_read;
  assign busy          = r_busy;
  assign done          = r_done;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a behavioural RAM and read-data fault injection.
module tb_ram_bist_ctrl;
  import ram_bist_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int AM = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          en_write;
  logic          write_enable;
  logic [AW-1:0] address_write;
  logic [DW-1:0] data_write;
  logic          en_read;
  logic [AW-1:0] address_read;
  logic [DW-1:0] data_read;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [AW+1:0] err_count;
  bist_state_t   dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  int fault_mode = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] mem [AM];
  logic [DW-1:0] ram_q;
  logic [AW-1:0] ram_q_addr;
  logic [DW-1:0] exp_q [$];

  ram_bist_ctrl #(
    .D_WIDTH (DW),
    .A_WIDTH (AW),
    .A_MAX   (AM),
    .PATTERN (16'hA5C3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .en_write      (en_write),
    .write_enable  (write_enable),
    .address_write (address_write),
    .data_write    (data_write),
    .en_read       (en_read),
    .address_read  (address_read),
    .data_read     (data_read),
    .busy          (busy),
    .done          (done),
    .fail          (fail),
    .fail_addr     (fail_addr),
    .err_count     (err_count),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // RAM model: registered read, one-cycle latency
  always @(posedge clk) begin
    if (en_write) mem[address_write] <= data_write;
    if (en_read) begin
      ram_q      <= mem[address_read];
      ram_q_addr <= address_read;
    end
  end

  always_comb begin
    data_read = ram_q;
    if (fault_mode == 2) data_read = '0;
    else if (fault_mode == 1 && ram_q_addr == AW'(5)) data_read = ram_q | DW'(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_val("excl_wr_rd", 32'(en_write & en_read), 32'd0);
      check_val("we_mirror", 32'(write_enable), 32'(en_write));
    end
  end

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Pulses start; returns the edge index (start-sampling edge = 0) where done is seen.
  task automatic run_test(input bit poke, output int done_edge);
    done_edge = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("wr0_first_en", 32'(en_write), 32'd1);
    check_val("wr0_first_addr", 32'(address_write), 32'd0);
    check_val("wr0_first_data", 32'(data_write), 32'hA5C3);
    check_val("busy_after_start", 32'(busy), 32'd1);
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      start = poke && (k == 10 || k == 40);
      if (k == 16) begin
        check_val("rd0_first_en", 32'(en_read), 32'd1);
        check_val("rd0_first_addr", 32'(address_read), 32'd0);
      end
      if (k == 33) begin
        check_val("wr1_first_en", 32'(en_write), 32'd1);
        check_val("wr1_first_data", 32'(data_write), 32'h5A3C);
      end
      if (done) begin
        done_edge = k;
        break;
      end
    end
    start = 1'b0;
    check_val("done_edge", 32'(done_edge), 32'd66);
    check_val("busy_at_done", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check_val("done_pulse_end", 32'(done), 32'd0);
    check_val("busy_fall", 32'(busy), 32'd0);
    check_val("state_idle_end", 32'(dbg_state), 32'(S_IDLE));
  endtask

  initial begin
    int de;
    int n_done;
    int second_edge;
    logic [DW-1:0] v;

    do_reset();
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_fail", 32'(fail), 32'd0);
    check_val("rst_fail_addr", 32'(fail_addr), 32'd0);
    check_val("rst_err", 32'(err_count), 32'd0);
    check_val("rst_en_wr", 32'(en_write), 32'd0);
    check_val("rst_en_rd", 32'(en_read), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk_en = 1'b1;

    // good RAM
    fault_mode = 0;
    run_test(1'b0, de);
    check_val("good_fail", 32'(fail), 32'd0);
    check_val("good_err", 32'(err_count), 32'd0);
    for (int a = 0; a < AM; a++) begin
      v = 16'hA5C3 ^ 16'(a);
      exp_q.push_back(~v);
    end
    for (int a = 0; a < AM; a++) begin
      check_val("mem_final", 32'(mem[a]), 32'(exp_q.pop_front()));
    end

    // address 5 bit 0 stuck-at-1: only phase 0 sees it
    fault_mode = 1;
    run_test(1'b0, de);
    check_val("sa1_fail", 32'(fail), 32'd1);
    check_val("sa1_fail_addr", 32'(fail_addr), 32'd5);
    check_val("sa1_err", 32'(err_count), 32'd1);

    // all reads return zero
    fault_mode = 2;
    run_test(1'b0, de);
    check_val("zero_fail", 32'(fail), 32'd1);
    check_val("zero_fail_addr", 32'(fail_addr), 32'd0);
    check_val("zero_err", 32'(err_count), 32'd32);

    // start pokes while busy are ignored; accepted start clears previous results
    fault_mode = 0;
    run_test(1'b1, de);
    check_val("poke_fail", 32'(fail), 32'd0);
    check_val("poke_err", 32'(err_count), 32'd0);

    // reset at edge 20 (mid RD0)
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k < 20; k++) begin
      @(posedge clk);
      #1;
    end
    check_val("mid_rd0_state", 32'(dbg_state), 32'(S_RD0));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_val("mr_state", 32'(dbg_state), 32'(S_IDLE));
    check_val("mr_busy", 32'(busy), 32'd0);
    check_val("mr_en_wr", 32'(en_write), 32'd0);
    check_val("mr_en_rd", 32'(en_read), 32'd0);
    check_val("mr_addr_rd", 32'(address_read), 32'd0);
    check_val("mr_done", 32'(done), 32'd0);
    check_val("mr_fail", 32'(fail), 32'd0);
    check_val("mr_err", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    check_val("mr_next_en_wr", 32'(en_write), 32'd0);
    check_val("mr_next_en_rd", 32'(en_read), 32'd0);
    run_test(1'b0, de);
    check_val("after_rst_err", 32'(err_count), 32'd0);

    // start held high: second run starts after a single IDLE cycle
    @(negedge clk);
    start = 1'b1;
    n_done = 0;
    second_edge = -1;
    for (int k = 0; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (n_done == 2) begin
          second_edge = k;
          break;
        end
      end
    end
    start = 1'b0;
    check_val("held_second_done", 32'(second_edge), 32'd134);
    repeat (2) @(posedge clk);
    #1;
    check_val("held_idle", 32'(busy), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
